gf22_rx_frame_buf: RTL and testbench

- Receive-side frame buffer for the Ethernet path; mirror of the TX buffer path.
- TX side: 32-bit words written in, bytes read out. This block: bytes written in, 32-bit words read out.
- Accepts a byte stream from the RX MAC (valid/ready/last), packs bytes little-endian into 32-bit words, stores one frame in a 2-port word memory and exposes it to the host side.
- Host reads the frame by word address and releases the buffer with an acknowledge; frames that overflow the buffer are dropped and counted.

---
 rtl/gf22_rx_frame_buf_if.sv | 31 +++
 rtl/gf22_rx_frame_buf.sv | 145 ++++++++++++++
 tb/tb_gf22_rx_frame_buf.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/gf22_rx_frame_buf_if.sv
// Host/MAC-side bundle for the RX frame buffer: byte stream in, frame
// status and word read port out.
interface gf22_rx_frame_buf_if #(
  parameter int ADDR_W = 9,
  parameter int LEN_W  = 12
);
  logic              s_valid;
  logic [7:0]        s_data;
  logic              s_last;
  logic              s_ready;
  logic              frame_valid;
  logic [LEN_W-1:0]  frame_len;
  logic              frame_ack;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [31:0]       rd_data;
  logic              drop_pulse;
  logic [15:0]       drop_cnt;

  // Driver side: the MAC byte source plus the host reader.
  modport master (
    output s_valid, s_data, s_last, frame_ack, rd_en, rd_addr,
    input  s_ready, frame_valid, frame_len, rd_data, drop_pulse, drop_cnt
  );

  // Buffer side.
  modport slave (
    input  s_valid, s_data, s_last, frame_ack, rd_en, rd_addr,
    output s_ready, frame_valid, frame_len, rd_data, drop_pulse, drop_cnt
  );
endinterface

// File: rtl/gf22_rx_frame_buf.sv
// RX frame buffer: packs an incoming byte stream little-endian into 32-bit
// words, holds one complete frame for the host, and drops (and counts)
// frames that do not fit.
module gf22_rx_frame_buf #(
  parameter int DEPTH_WORDS = 512,
  parameter int ADDR_W      = 9,
  parameter int LEN_W       = 12
) (
  input  logic                clkA,
  input  logic                rstnA,
  gf22_rx_frame_buf_if.slave  bus
);

  localparam logic [LEN_W-1:0] MAX_BYTES = LEN_W'(4 * DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, RECV, DONE, DROP} state_t;

  state_t            r_state;
  logic [LEN_W-1:0]  r_cnt;
  logic [LEN_W-1:0]  r_frameLen;
  logic [23:0]       r_pack;
  logic              r_sReady;
  logic              r_frameValid;
  logic              r_dropPulse;
  logic [15:0]       r_dropCnt;
  logic [31:0]       r_rdData;
  logic [31:0]       r_mem [DEPTH_WORDS];

  logic              w_accept;
  logic              w_filling;
  logic              w_overflow;
  logic [1:0]        w_lane;
  logic              w_wrEn;
  logic [ADDR_W-1:0] w_wrAddr;
  logic [31:0]       w_wrWord;
  logic              w_dropDone;

  // A byte is taken whenever the source offers one and we are ready; the
  // buffer is full once the byte counter has reached the full capacity.
  assign w_accept   = bus.s_valid & r_sReady;
  assign w_filling  = (r_state == IDLE) | (r_state == RECV);
  assign w_overflow = (r_cnt == MAX_BYTES);
  assign w_lane     = r_cnt[1:0];

  // Close a word on the top lane or on the final byte; the incoming byte is
  // merged above the lanes already packed, upper unused lanes stay zero.
  assign w_wrEn   = w_accept & w_filling & ~w_overflow &
                    ((w_lane == 2'd3) | bus.s_last);
  assign w_wrAddr = r_cnt[ADDR_W+1:2];
  assign w_wrWord = {8'b0, r_pack} | ({24'b0, bus.s_data} << {w_lane, 3'b000});

  // A dropped frame ends on its last byte, either while already discarding
  // or when the overflowing byte is itself the last one.
  assign w_dropDone = w_accept & bus.s_last &
                      ((r_state == DROP) | (w_filling & w_overflow));

  // Frame receive / hold / drop state machine with registered outputs.
  always_ff @(posedge clkA) begin
    if (!rstnA) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_pack       <= '0;
      r_sReady     <= 1'b1;
      r_frameValid <= 1'b0;
      r_frameLen   <= '0;
      r_dropPulse  <= 1'b0;
      r_dropCnt    <= '0;
    end else begin
      r_dropPulse <= 1'b0;
      if (w_dropDone) begin
        r_state     <= IDLE;
        r_cnt       <= '0;
        r_pack      <= '0;
        r_dropPulse <= 1'b1;
        if (r_dropCnt != 16'hFFFF) begin
          r_dropCnt <= r_dropCnt + 16'd1;
        end
      end else begin
        case (r_state)
          IDLE, RECV: begin
            if (w_accept) begin
              if (w_overflow) begin
                r_state <= DROP;
              end else begin
                r_cnt <= r_cnt + LEN_W'(1);
                if (w_wrEn) begin
                  r_pack <= '0;
                end else begin
                  r_pack <= w_wrWord[23:0];
                end
                if (bus.s_last) begin
                  r_state      <= DONE;
                  r_sReady     <= 1'b0;
                  r_frameValid <= 1'b1;
                  r_frameLen   <= r_cnt + LEN_W'(1);
                end else begin
                  r_state <= RECV;
                end
              end
            end
          end
          DONE: begin
            if (bus.frame_ack) begin
              r_state      <= IDLE;
              r_sReady     <= 1'b1;
              r_frameValid <= 1'b0;
              r_cnt        <= '0;
            end
          end
          DROP: begin
            r_state <= DROP;
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  // Word memory write side; contents deliberately survive reset.
  always_ff @(posedge clkA) begin
    if (w_wrEn) begin
      r_mem[w_wrAddr] <= w_wrWord;
    end
  end

  // Host read port: one-cycle latency, holds when not enabled, old data on
  // a same-cycle write to the same word.
  always_ff @(posedge clkA) begin
    if (!rstnA) begin
      r_rdData <= '0;
    end else if (bus.rd_en) begin
      r_rdData <= r_mem[bus.rd_addr];
    end
  end

  assign bus.s_ready     = r_sReady;
  assign bus.frame_valid = r_frameValid;
  assign bus.frame_len   = r_frameLen;
  assign bus.rd_data     = r_rdData;
  assign bus.drop_pulse  = r_dropPulse;
  assign bus.drop_cnt    = r_dropCnt;

endmodule

// File: tb/tb_gf22_rx_frame_buf.sv
// Directed, table-driven bench for the RX frame buffer plus hand-written
// sequences for full-size, overflow and mid-frame reset cases.
module tb_gf22_rx_frame_buf;

  logic clkA;
  logic rstnA;

  gf22_rx_frame_buf_if #(.ADDR_W(9), .LEN_W(12)) bus ();

  gf22_rx_frame_buf #(.DEPTH_WORDS(512), .ADDR_W(9), .LEN_W(12)) dut (
    .clkA  (clkA),
    .rstnA (rstnA),
    .bus   (bus)
  );

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        l;
    logic        ack;
    logic        rdEn;
    logic [8:0]  addr;
    logic        eReady;
    logic        eFv;
    logic [11:0] eLen;
    logic [31:0] eRd;
    logic        eDp;
    logic [15:0] eDc;
  } vec_t;

  localparam int NUM_VECS = 21;

  vec_t vecs [NUM_VECS];
  int   nVectors;
  int   nMiscompares;
  logic [31:0] expRd;
  logic [15:0] expDc;

  // 100 MHz clock
  initial begin
    clkA = 1'b0;
    forever #5 clkA = ~clkA;
  end

  function automatic vec_t mkVec(logic v, logic [7:0] d, logic l, logic ack,
                                 logic rdEn, logic [8:0] addr, logic eReady,
                                 logic eFv, logic [11:0] eLen, logic [31:0] eRd,
                                 logic eDp, logic [15:0] eDc);
    vec_t r;
    r.v = v; r.d = d; r.l = l; r.ack = ack; r.rdEn = rdEn; r.addr = addr;
    r.eReady = eReady; r.eFv = eFv; r.eLen = eLen; r.eRd = eRd;
    r.eDp = eDp; r.eDc = eDc;
    return r;
  endfunction

  // Drive one cycle of inputs, then land 1 time unit after the clock edge
  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic l,
                               input logic ack, input logic rdEn,
                               input logic [8:0] addr);
    bus.s_valid   = v;
    bus.s_data    = d;
    bus.s_last    = l;
    bus.frame_ack = ack;
    bus.rd_en     = rdEn;
    bus.rd_addr   = addr;
    @(posedge clkA);
    #1;
  endtask

  // Compare the whole output bundle against expected values
  task automatic checkOutput(input string name, input logic eReady,
                             input logic eFv, input logic [11:0] eLen,
                             input logic [31:0] eRd, input logic eDp,
                             input logic [15:0] eDc);
    logic [62:0] act;
    logic [62:0] exp;
    act = {bus.s_ready, bus.frame_valid, bus.frame_len, bus.rd_data,
           bus.drop_pulse, bus.drop_cnt};
    exp = {eReady, eFv, eLen, eRd, eDp, eDc};
    nVectors++;
    if (act !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got rdy=%b fv=%b len=%0d rd=%h dp=%b dc=%0d, expected rdy=%b fv=%b len=%0d rd=%h dp=%b dc=%0d",
               name, bus.s_ready, bus.frame_valid, bus.frame_len, bus.rd_data,
               bus.drop_pulse, bus.drop_cnt, eReady, eFv, eLen, eRd, eDp, eDc);
    end
  endtask

  initial begin
    nVectors     = 0;
    nMiscompares = 0;

    //             v  data   l  ack rdEn addr | rdy fv len  rdData        dp dc
    vecs[0]  = mkVec(1, 8'h11, 0, 0, 0, 9'd0,   1, 0, 12'd0, 32'h0,        0, 16'd0);
    vecs[1]  = mkVec(1, 8'h22, 0, 0, 0, 9'd0,   1, 0, 12'd0, 32'h0,        0, 16'd0);
    vecs[2]  = mkVec(1, 8'h33, 0, 0, 0, 9'd0,   1, 0, 12'd0, 32'h0,        0, 16'd0);
    vecs[3]  = mkVec(1, 8'h44, 0, 0, 0, 9'd0,   1, 0, 12'd0, 32'h0,        0, 16'd0);
    vecs[4]  = mkVec(1, 8'h55, 0, 0, 0, 9'd0,   1, 0, 12'd0, 32'h0,        0, 16'd0);
    vecs[5]  = mkVec(1, 8'h66, 1, 0, 0, 9'd0,   0, 1, 12'd6, 32'h0,        0, 16'd0);
    vecs[6]  = mkVec(0, 8'h00, 0, 0, 1, 9'd0,   0, 1, 12'd6, 32'h44332211, 0, 16'd0);
    vecs[7]  = mkVec(0, 8'h00, 0, 0, 1, 9'd1,   0, 1, 12'd6, 32'h00006655, 0, 16'd0);
    vecs[8]  = mkVec(0, 8'h00, 0, 0, 0, 9'd0,   0, 1, 12'd6, 32'h00006655, 0, 16'd0);
    vecs[9]  = mkVec(1, 8'hA1, 0, 0, 0, 9'd0,   0, 1, 12'd6, 32'h00006655, 0, 16'd0);
    vecs[10] = mkVec(1, 8'hA1, 0, 1, 0, 9'd0,   1, 0, 12'd6, 32'h00006655, 0, 16'd0);
    vecs[11] = mkVec(1, 8'hA1, 0, 0, 0, 9'd0,   1, 0, 12'd6, 32'h00006655, 0, 16'd0);
    vecs[12] = mkVec(1, 8'hA2, 1, 0, 0, 9'd0,   0, 1, 12'd2, 32'h00006655, 0, 16'd0);
    vecs[13] = mkVec(0, 8'h00, 0, 1, 1, 9'd0,   1, 0, 12'd2, 32'h0000A2A1, 0, 16'd0);
    vecs[14] = mkVec(0, 8'h00, 0, 1, 0, 9'd0,   1, 0, 12'd2, 32'h0000A2A1, 0, 16'd0);
    vecs[15] = mkVec(0, 8'h00, 0, 0, 0, 9'd0,   1, 0, 12'd2, 32'h0000A2A1, 0, 16'd0);
    vecs[16] = mkVec(0, 8'hAB, 0, 0, 0, 9'd0,   1, 0, 12'd2, 32'h0000A2A1, 0, 16'd0);
    vecs[17] = mkVec(1, 8'hAB, 1, 0, 0, 9'd0,   0, 1, 12'd1, 32'h0000A2A1, 0, 16'd0);
    vecs[18] = mkVec(0, 8'h00, 0, 0, 1, 9'd0,   0, 1, 12'd1, 32'h000000AB, 0, 16'd0);
    vecs[19] = mkVec(0, 8'h00, 0, 1, 0, 9'd0,   1, 0, 12'd1, 32'h000000AB, 0, 16'd0);
    vecs[20] = mkVec(0, 8'h00, 0, 0, 1, 9'd1,   1, 0, 12'd1, 32'h00006655, 0, 16'd0);

    // Reset
    rstnA = 1'b0;
    applyStimulus(0, 8'h00, 0, 0, 0, 9'd0);
    applyStimulus(0, 8'h00, 0, 0, 0, 9'd0);
    checkOutput("reset", 1, 0, 12'd0, 32'h0, 0, 16'd0);
    rstnA = 1'b1;

    // Table: 6-byte frame, reads, back-pressure in DONE, 1-byte frame
    for (int i = 0; i < NUM_VECS; i++) begin
      applyStimulus(vecs[i].v, vecs[i].d, vecs[i].l, vecs[i].ack,
                    vecs[i].rdEn, vecs[i].addr);
      checkOutput($sformatf("vec%0d", i), vecs[i].eReady, vecs[i].eFv,
                  vecs[i].eLen, vecs[i].eRd, vecs[i].eDp, vecs[i].eDc);
    end

    // Reset in the middle of a frame abandons it
    applyStimulus(1, 8'h10, 0, 0, 0, 9'd0);
    applyStimulus(1, 8'h20, 0, 0, 0, 9'd0);
    applyStimulus(1, 8'h30, 0, 0, 0, 9'd0);
    rstnA = 1'b0;
    applyStimulus(0, 8'h00, 0, 0, 0, 9'd0);
    rstnA = 1'b1;
    checkOutput("midReset", 1, 0, 12'd0, 32'h0, 0, 16'd0);
    applyStimulus(1, 8'h01, 0, 0, 0, 9'd0);
    applyStimulus(1, 8'h02, 0, 0, 0, 9'd0);
    applyStimulus(1, 8'h03, 0, 0, 0, 9'd0);
    applyStimulus(1, 8'h04, 1, 0, 0, 9'd0);
    checkOutput("postResetLen", 0, 1, 12'd4, 32'h0, 0, 16'd0);
    applyStimulus(0, 8'h00, 0, 0, 1, 9'd0);
    checkOutput("postResetWord0", 0, 1, 12'd4, 32'h04030201, 0, 16'd0);
    applyStimulus(0, 8'h00, 0, 1, 0, 9'd0);
    checkOutput("postResetAck", 1, 0, 12'd4, 32'h04030201, 0, 16'd0);
    expRd = 32'h04030201;
    expDc = 16'd0;

    // Largest legal frame: 2048 bytes
    for (int i = 0; i < 2048; i++) begin
      applyStimulus(1, 8'(i), (i == 2047), 0, 0, 9'd0);
      if (i == 2046) checkOutput("full2046", 1, 0, 12'd4, expRd, 0, expDc);
    end
    checkOutput("fullLen", 0, 1, 12'd2048, expRd, 0, expDc);
    applyStimulus(0, 8'h00, 0, 0, 1, 9'd511);
    checkOutput("fullWord511", 0, 1, 12'd2048, 32'hFFFEFDFC, 0, expDc);
    applyStimulus(0, 8'h00, 0, 0, 1, 9'd0);
    checkOutput("fullWord0", 0, 1, 12'd2048, 32'h03020100, 0, expDc);
    applyStimulus(0, 8'h00, 0, 1, 0, 9'd0);
    checkOutput("fullAck", 1, 0, 12'd2048, 32'h03020100, 0, expDc);
    expRd = 32'h03020100;

    // 2049 bytes: overflowing byte carries last, dropped at once
    for (int i = 0; i < 2049; i++) begin
      applyStimulus(1, 8'(i) ^ 8'h5A, (i == 2048), 0, 0, 9'd0);
      if (i == 2047) checkOutput("ovf2047", 1, 0, 12'd2048, expRd, 0, expDc);
    end
    expDc = 16'd1;
    checkOutput("ovfDropPulse", 1, 0, 12'd2048, expRd, 1, expDc);
    applyStimulus(0, 8'h00, 0, 0, 1, 9'd0);
    checkOutput("ovfWord0", 1, 0, 12'd2048, 32'h59585B5A, 0, expDc);
    applyStimulus(0, 8'h00, 0, 0, 1, 9'd511);
    checkOutput("ovfWord511", 1, 0, 12'd2048, 32'hA5A4A7A6, 0, expDc);
    expRd = 32'hA5A4A7A6;

    // 2050 bytes: passes through the discard state before the last byte
    for (int i = 0; i < 2050; i++) begin
      applyStimulus(1, 8'(i), (i == 2049), 0, 0, 9'd0);
      if (i == 2048) checkOutput("dropState", 1, 0, 12'd2048, expRd, 0, expDc);
    end
    expDc = 16'd2;
    checkOutput("dropPulse2", 1, 0, 12'd2048, expRd, 1, expDc);
    applyStimulus(0, 8'h00, 0, 0, 0, 9'd0);
    checkOutput("dropPulseEnd", 1, 0, 12'd2048, expRd, 0, expDc);

    // Short frame after a drop starts counting from zero again
    applyStimulus(1, 8'hC1, 0, 0, 0, 9'd0);
    applyStimulus(1, 8'hC2, 1, 0, 0, 9'd0);
    checkOutput("afterDropLen", 0, 1, 12'd2, expRd, 0, expDc);
    applyStimulus(0, 8'h00, 0, 0, 1, 9'd0);
    checkOutput("afterDropWord0", 0, 1, 12'd2, 32'h0000C2C1, 0, expDc);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
